processor_core: RTL and testbench
=================================

Name: processor_core

Overview:
- Multicycle, non-pipelined 32-bit CPU core implementing the team's 350 integer ISA subset.
- Regfile, instruction ROM and data RAM are external. The core drives their address and control lines and consumes their read data.
- The core also owns a 6-bit memory-mapped output port (JA) that drives the stepper/peripheral header.
- Instantiated in the top-level wrapper beside regfile, ROM (imem) and RAM (dmem).

Parameters:
- JA_ADDR, 12'hFFF, dmem word address whose store also updates JA.
- RESET_PC, 32'd0, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- address_imem  out  32  PC; only [11:0] are used by the ROM.
- q_imem  in  32  instruction word; the ROM registers it, so it is valid one posedge after address_imem is presented.
- ctrl_writeEnable  out  1  regfile write enable.
- ctrl_writeReg  out  5  regfile write index.
- ctrl_readRegA  out  5  regfile read index A (rs).
- ctrl_readRegB  out  5  regfile read index B (rt, or rd for sw/bne/blt/jr).
- data_writeReg  out  32  regfile write data.
- data_readRegA  in  32  combinational read data A.
- data_readRegB  in  32  combinational read data B.
- wren  out  1  dmem write enable.
- address_dmem  out  32  dmem address; [11:0] are used.
- data  out  32  dmem write data.
- q_dmem  in  32  dmem read data, registered (valid one posedge after address).
- JA  out  6  peripheral output register.

Behaviour:
- Reset: PC=RESET_PC, state=FETCH, JA=0, instruction register=0. All write enables are low during reset.
- Instruction formats:
  - opcode [31:27]; rd [26:22]; rs [21:17]; rt [16:12]; shamt [11:7]; aluop [6:2].
  - imm17 [16:0], sign-extended; target27 [26:0], zero-extended.
- FSM: FETCH -> DECODE -> EXEC -> WB -> FETCH. Every instruction takes exactly 4 cycles.
  - FETCH: address_imem=PC; the ROM captures it.
  - DECODE: latch q_imem into IR.
  - EXEC: drive read indices from IR; compute ALU result and branch decision; drive dmem address and data. wren=1 only for sw in this state.
  - WB: for lw, q_dmem is now valid. The regfile write is asserted here (rwe=1 for one cycle). PC updates at the end of WB.
- Read indices: readRegA=rs. readRegB=rt for R-type, otherwise rd. bex reads r30 on port A.
- R-type (opcode 00000), aluop:
  - add 00000, sub 00001, and 00010, or 00011.
  - sll 00100 and sra 00101 shift rs by shamt.
  - Other aluops are NOPs: no write.
- I/J-type opcodes:
  - addi 00101: rd=rs+imm.
  - sw 00111: M[rs+imm]=rd.
  - lw 01000: rd=M[rs+imm].
  - j 00001: PC=T.
  - jal 00011: r31=PC+1, then PC=T.
  - jr 00100: PC=$rd.
  - bne 00010: if rd!=rs, PC=PC+1+imm.
  - blt 00110: if $rd<$rs (signed), PC=PC+1+imm.
  - setx 10101: r30=T.
  - bex 10110: if r30!=0, PC=T.
  - Any unlisted opcode is a NOP.
- PC otherwise advances by 1 per instruction (word addressing), 32-bit wrap.
- Overflow (signed, two's complement): on add/addi/sub overflow, write 1/2/3 respectively to r30 instead of rd.
- Writes targeting r0 may be issued; the regfile ignores them. The core must not rely on r0 writes.
- JA: a sw whose address_dmem[11:0]==JA_ADDR loads JA<=data[5:0] at the EXEC posedge. The RAM is also written (wren is not suppressed).
- Reset asserted in any state aborts the instruction in flight: no write completes, and FETCH restarts at RESET_PC on the next cycle.

Decomposition:
- Shared package: opcode and aluop constants, field bit positions, FSM state encoding, overflow codes 1/2/3, register indices 30/31.
- One natural sub-module: alu_32 (add/sub/and/or/sll/sra, signed overflow flag, not-equal and less-than outputs). The FSM and datapath stay in processor_core.

Test Plan:
- addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12; writes visible in cycles 3, 7, 11 after reset; r0 stays 0.
- addi r1,r0,100; sw r1,4(r0); lw r4,4(r0) -> r4=100; wren high exactly one cycle with address_dmem=4, data=100.
- r1=0x7FFFFFFF, add r2,r1,r1 -> r30=1 and r2 unchanged. sub 0x80000000-1 -> r30=3. addi overflow -> r30=2.
- bne, blt, j, jal, jr loop running 3 iterations -> counter register=3; r31 = jal address+1; taken/not-taken branches skip or execute correctly.
- setx 5; bex target -> branch taken. setx 0; bex -> falls through.
- addi r1,r0,0x2A; sw r1,4095(r0) -> JA=6'b101010. Assert reset mid-EXEC of a following sw -> JA holds its value, no wren pulse, PC=0 afterward.

Source files
------------

// File: rtl/processor_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : processor_core_pkg
//  Description : Shared encodings for the multicycle 350-subset core:
//                instruction field positions, opcodes, ALU operations,
//                FSM state encoding, overflow codes and special registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package processor_core_pkg;

    // Instruction field positions (LSB of each 5-bit field)
    localparam int c_opc_lsb   = 27;
    localparam int c_rd_lsb    = 22;
    localparam int c_rs_lsb    = 17;
    localparam int c_rt_lsb    = 12;
    localparam int c_shamt_lsb = 7;
    localparam int c_aluop_lsb = 2;
    localparam int c_imm_w     = 17;
    localparam int c_tgt_w     = 27;

    // Opcodes
    localparam logic [4:0] c_op_rtype = 5'b00000;
    localparam logic [4:0] c_op_j     = 5'b00001;
    localparam logic [4:0] c_op_bne   = 5'b00010;
    localparam logic [4:0] c_op_jal   = 5'b00011;
    localparam logic [4:0] c_op_jr    = 5'b00100;
    localparam logic [4:0] c_op_addi  = 5'b00101;
    localparam logic [4:0] c_op_blt   = 5'b00110;
    localparam logic [4:0] c_op_sw    = 5'b00111;
    localparam logic [4:0] c_op_lw    = 5'b01000;
    localparam logic [4:0] c_op_setx  = 5'b10101;
    localparam logic [4:0] c_op_bex   = 5'b10110;

    // R-type ALU operations
    localparam logic [4:0] c_alu_add = 5'b00000;
    localparam logic [4:0] c_alu_sub = 5'b00001;
    localparam logic [4:0] c_alu_and = 5'b00010;
    localparam logic [4:0] c_alu_or  = 5'b00011;
    localparam logic [4:0] c_alu_sll = 5'b00100;
    localparam logic [4:0] c_alu_sra = 5'b00101;

    // Status codes written to r30 when an arithmetic result overflows
    localparam logic [31:0] c_ovf_add  = 32'd1;
    localparam logic [31:0] c_ovf_addi = 32'd2;
    localparam logic [31:0] c_ovf_sub  = 32'd3;

    // Architecturally special registers
    localparam logic [4:0] c_reg_status = 5'd30;
    localparam logic [4:0] c_reg_link   = 5'd31;

    // Four-phase instruction sequencer
    typedef enum logic [1:0] {
        c_st_fetch  = 2'd0,
        c_st_decode = 2'd1,
        c_st_exec   = 2'd2,
        c_st_wb     = 2'd3
    } state_t;

    // Sign-extend the 17-bit immediate to a full word
    function automatic logic [31:0] sext_imm(input logic [16:0] imm);
        return {{15{imm[16]}}, imm};
    endfunction

    // Only aluops add..sra produce a register write; the rest are NOPs
    function automatic logic aluop_valid(input logic [4:0] op);
        return (op <= c_alu_sra);
    endfunction

endpackage
`default_nettype wire

// File: rtl/processor_core_alu_32.sv
`default_nettype none
// ============================================================================
//  Module      : alu_32
//  Description : 32-bit integer ALU: add/sub/and/or/sll/sra with signed
//                overflow, plus not-equal and signed less-than compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_32
    import processor_core_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_aluop,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_result,
    output logic        o_overflow,
    output logic        o_not_equal,
    output logic        o_less_than
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    // Operation select; overflow only meaningful for add and sub
    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_aluop)
            c_alu_add: begin
                o_result   = w_sum;
                o_overflow = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            end
            c_alu_sub: begin
                o_result   = w_diff;
                o_overflow = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
            end
            c_alu_and: o_result = i_a & i_b;
            c_alu_or:  o_result = i_a | i_b;
            c_alu_sll: o_result = i_a << i_shamt;
            c_alu_sra: o_result = $unsigned($signed(i_a) >>> i_shamt);
            default:   o_result = '0;
        endcase
    end

    assign o_not_equal = (i_a != i_b);
    assign o_less_than = ($signed(i_a) < $signed(i_b));

endmodule
`default_nettype wire

// File: rtl/processor_core.sv
`default_nettype none
// ============================================================================
//  Module      : processor_core
//  Description : Multicycle (FETCH/DECODE/EXEC/WB) 32-bit core for the
//                350 integer subset. Regfile, imem and dmem are external;
//                a store to JA_ADDR also updates the 6-bit JA port.
//  Revision    : 1.0 - initial release
// ============================================================================
module processor_core #(
    parameter logic [11:0] JA_ADDR  = 12'hFFF,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        wren,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    input  logic [31:0] q_dmem,
    output logic [5:0]  JA
);

    import processor_core_pkg::*;

    // Architectural and sequencing state
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_next_pc;
    logic        r_rwe;
    logic [4:0]  r_wreg;
    logic [31:0] r_wdata;
    logic        r_wb_from_mem;

    // Decoded instruction fields
    logic [4:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_shamt;
    logic [4:0]  w_aluop;
    logic [31:0] w_imm;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus1;

    assign w_opcode   = r_ir[c_opc_lsb   +: 5];
    assign w_rd       = r_ir[c_rd_lsb    +: 5];
    assign w_rs       = r_ir[c_rs_lsb    +: 5];
    assign w_rt       = r_ir[c_rt_lsb    +: 5];
    assign w_shamt    = r_ir[c_shamt_lsb +: 5];
    assign w_aluop    = r_ir[c_aluop_lsb +: 5];
    assign w_imm      = sext_imm(r_ir[c_imm_w-1:0]);
    assign w_target   = {5'd0, r_ir[c_tgt_w-1:0]};
    assign w_pc_plus1 = r_pc + 32'd1;

    // Regfile read ports: bex inspects r30, non-R-type reads rd on port B
    always_comb begin
        ctrl_readRegA = (w_opcode == c_op_bex) ? c_reg_status : w_rs;
        ctrl_readRegB = (w_opcode == c_op_rtype) ? w_rt : w_rd;
    end

    // ALU operand routing; branches compare $rd against $rs
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [4:0]  w_alu_op;

    always_comb begin
        w_alu_a  = data_readRegA;
        w_alu_b  = w_imm;
        w_alu_op = c_alu_add;
        case (w_opcode)
            c_op_rtype: begin
                w_alu_b  = data_readRegB;
                w_alu_op = w_aluop;
            end
            c_op_bne, c_op_blt: begin
                w_alu_a  = data_readRegB;
                w_alu_b  = data_readRegA;
                w_alu_op = c_alu_sub;
            end
            default: ;
        endcase
    end

    logic [31:0] w_alu_result;
    logic        w_alu_ovf;
    logic        w_alu_ne;
    logic        w_alu_lt;

    alu_32 u_alu (
        .i_a         (w_alu_a),
        .i_b         (w_alu_b),
        .i_aluop     (w_alu_op),
        .i_shamt     (w_shamt),
        .o_result    (w_alu_result),
        .o_overflow  (w_alu_ovf),
        .o_not_equal (w_alu_ne),
        .o_less_than (w_alu_lt)
    );

    // Execute-stage decisions: register write target/data and next PC
    logic        w_wr_en;
    logic [4:0]  w_wr_reg;
    logic [31:0] w_wr_data;
    logic        w_wr_from_mem;
    logic [31:0] w_next_pc;

    always_comb begin
        w_wr_en       = 1'b0;
        w_wr_reg      = w_rd;
        w_wr_data     = w_alu_result;
        w_wr_from_mem = 1'b0;
        w_next_pc     = w_pc_plus1;
        case (w_opcode)
            c_op_rtype: begin
                if (aluop_valid(w_aluop)) begin
                    w_wr_en = 1'b1;
                    if (w_alu_ovf) begin
                        w_wr_reg  = c_reg_status;
                        w_wr_data = (w_aluop == c_alu_sub) ? c_ovf_sub : c_ovf_add;
                    end
                end
            end
            c_op_addi: begin
                w_wr_en = 1'b1;
                if (w_alu_ovf) begin
                    w_wr_reg  = c_reg_status;
                    w_wr_data = c_ovf_addi;
                end
            end
            c_op_lw: begin
                w_wr_en       = 1'b1;
                w_wr_from_mem = 1'b1;
            end
            c_op_j: w_next_pc = w_target;
            c_op_jal: begin
                w_wr_en   = 1'b1;
                w_wr_reg  = c_reg_link;
                w_wr_data = w_pc_plus1;
                w_next_pc = w_target;
            end
            c_op_jr: w_next_pc = data_readRegB;
            c_op_bne: begin
                if (w_alu_ne) w_next_pc = w_pc_plus1 + w_imm;
            end
            c_op_blt: begin
                if (w_alu_lt) w_next_pc = w_pc_plus1 + w_imm;
            end
            c_op_setx: begin
                w_wr_en   = 1'b1;
                w_wr_reg  = c_reg_status;
                w_wr_data = w_target;
            end
            c_op_bex: begin
                if (data_readRegA != 32'd0) w_next_pc = w_target;
            end
            default: ;
        endcase
    end

    // Instruction sequencer: latch IR, capture WB intent, commit PC in WB
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_st_fetch;
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_next_pc     <= RESET_PC;
            r_rwe         <= 1'b0;
            r_wreg        <= '0;
            r_wdata       <= '0;
            r_wb_from_mem <= 1'b0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    r_state <= c_st_decode;
                end
                c_st_decode: begin
                    r_ir    <= q_imem;
                    r_state <= c_st_exec;
                end
                c_st_exec: begin
                    r_rwe         <= w_wr_en;
                    r_wreg        <= w_wr_reg;
                    r_wdata       <= w_wr_data;
                    r_wb_from_mem <= w_wr_from_mem;
                    r_next_pc     <= w_next_pc;
                    r_state       <= c_st_wb;
                end
                c_st_wb: begin
                    r_pc    <= r_next_pc;
                    r_rwe   <= 1'b0;
                    r_state <= c_st_fetch;
                end
                default: r_state <= c_st_fetch;
            endcase
        end
    end

    // Memory-mapped JA port follows any store to JA_ADDR
    always_ff @(posedge clock) begin
        if (reset) begin
            JA <= '0;
        end else if ((r_state == c_st_exec) && (w_opcode == c_op_sw) &&
                     (w_alu_result[11:0] == JA_ADDR)) begin
            JA <= data_readRegB[5:0];
        end
    end

    // External interface; write enables are forced low while reset is high
    assign address_imem     = r_pc;
    assign ctrl_writeEnable = r_rwe & ~reset;
    assign ctrl_writeReg    = r_wreg;
    assign data_writeReg    = r_wb_from_mem ? q_dmem : r_wdata;
    assign wren             = (r_state == c_st_exec) && (w_opcode == c_op_sw) && !reset;
    assign address_dmem     = w_alu_result;
    assign data             = data_readRegB;

endmodule
`default_nettype wire

// File: tb/tb_processor_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_processor_core
//  Description : Directed self-checking bench for processor_core with
//                behavioural regfile, registered ROM and registered RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_processor_core;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [31:0] NOP    = 32'hF800_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load  = 1'b1;
    logic [31:0] address_imem;
    logic [31:0] q_imem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;
    logic [5:0]  JA;

    logic [31:0] rom       [0:4095];
    logic [31:0] ram       [0:4095];
    logic [31:0] regs      [0:31];
    logic [31:0] init_regs [0:31];

    int compared   = 0;
    int mismatched = 0;

    processor_core dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .q_imem           (q_imem),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .wren             (wren),
        .address_dmem     (address_dmem),
        .data             (data),
        .q_dmem           (q_dmem),
        .JA               (JA)
    );

    always #5 clock = ~clock;

    // Memories and regfile models
    always @(posedge clock) begin
        q_imem <= rom[address_imem[11:0]];
        q_dmem <= ram[address_dmem[11:0]];
        if (load) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= init_regs[i];
        end else begin
            if (wren) ram[address_dmem[11:0]] <= data;
            if (ctrl_writeEnable && (ctrl_writeReg != 5'd0))
                regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    assign data_readRegA = regs[ctrl_readRegA];
    assign data_readRegB = regs[ctrl_readRegB];

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] sh,
                                          input logic [4:0] op);
        return {OP_R, rd, rs, rt, sh, op, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
        return {op, t};
    endfunction

    task automatic clear_program();
        for (int i = 0; i < 4096; i++) rom[i] = NOP;
        for (int i = 0; i < 32; i++) init_regs[i] = 32'd0;
    endtask

    // Hold reset while the regfile/RAM models load; returns at start of cycle 0
    task automatic start_program();
        reset = 1'b1;
        load  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        load  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_program();
        reset = 1'b1;
        load  = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        compared++;
        if (address_imem !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_pc: got %0h expected 0", address_imem);
        end
        compared++;
        if (wren !== 1'b0 || ctrl_writeEnable !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_we: got wren=%0b rwe=%0b expected 0/0", wren, ctrl_writeEnable);
        end
        compared++;
        if (JA !== 6'd0) begin
            mismatched++;
            $display("FAIL reset_ja: got %0h expected 0", JA);
        end
    endtask

    task automatic test_basic();
        logic exp_we;
        clear_program();
        rom[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 17'd5);
        rom[1] = enc_i(OP_ADDI, 5'd2, 5'd0, 17'd7);
        rom[2] = enc_r(5'd3, 5'd1, 5'd2, 5'd0, 5'b00000);
        start_program();
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            exp_we = (k == 3) || (k == 7) || (k == 11);
            compared++;
            if (ctrl_writeEnable !== exp_we) begin
                mismatched++;
                $display("FAIL basic_we_cycle%0d: got %0b expected %0b", k, ctrl_writeEnable, exp_we);
            end
            if (k == 11) begin
                compared++;
                if (ctrl_writeReg !== 5'd3 || data_writeReg !== 32'd12) begin
                    mismatched++;
                    $display("FAIL basic_add_wb: got r%0d=%0h expected r3=c", ctrl_writeReg, data_writeReg);
                end
            end
            @(posedge clock);
            #1;
        end
        compared++;
        if (regs[1] !== 32'd5 || regs[2] !== 32'd7 || regs[3] !== 32'd12) begin
            mismatched++;
            $display("FAIL basic_regs: got %0h %0h %0h expected 5 7 c", regs[1], regs[2], regs[3]);
        end
    endtask

    task automatic test_load_store();
        clear_program();
        rom[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 17'd100);
        rom[1] = enc_i(OP_SW,   5'd1, 5'd0, 17'd4);
        rom[2] = enc_i(OP_LW,   5'd4, 5'd0, 17'd4);
        start_program();
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            compared++;
            if (wren !== (k == 6)) begin
                mismatched++;
                $display("FAIL mem_wren_cycle%0d: got %0b expected %0b", k, wren, (k == 6));
            end
            if (k == 6) begin
                compared++;
                if (address_dmem !== 32'd4 || data !== 32'd100) begin
                    mismatched++;
                    $display("FAIL mem_sw_bus: got addr=%0h data=%0h expected 4/64", address_dmem, data);
                end
            end
            @(posedge clock);
            #1;
        end
        compared++;
        if (regs[4] !== 32'd100 || ram[4] !== 32'd100) begin
            mismatched++;
            $display("FAIL mem_lw: got r4=%0h M4=%0h expected 64/64", regs[4], ram[4]);
        end
    endtask

    task automatic test_overflow();
        clear_program();
        init_regs[1] = 32'h7FFF_FFFF;
        init_regs[2] = 32'h0000_1234;
        init_regs[5] = 32'h8000_0000;
        init_regs[6] = 32'd1;
        init_regs[7] = 32'h55;
        init_regs[8] = 32'h66;
        rom[0] = enc_r(5'd2, 5'd1, 5'd1, 5'd0, 5'b00000);
        rom[1] = enc_r(5'd7, 5'd5, 5'd6, 5'd0, 5'b00001);
        rom[2] = enc_i(OP_ADDI, 5'd8, 5'd1, 17'd1);
        rom[3] = enc_j(OP_J, 27'd3);
        start_program();
        run_cycles(4);
        compared++;
        if (regs[30] !== 32'd1 || regs[2] !== 32'h1234) begin
            mismatched++;
            $display("FAIL ovf_add: got r30=%0h r2=%0h expected 1/1234", regs[30], regs[2]);
        end
        run_cycles(4);
        compared++;
        if (regs[30] !== 32'd3 || regs[7] !== 32'h55) begin
            mismatched++;
            $display("FAIL ovf_sub: got r30=%0h r7=%0h expected 3/55", regs[30], regs[7]);
        end
        run_cycles(4);
        compared++;
        if (regs[30] !== 32'd2 || regs[8] !== 32'h66) begin
            mismatched++;
            $display("FAIL ovf_addi: got r30=%0h r8=%0h expected 2/66", regs[30], regs[8]);
        end
    endtask

    task automatic test_alu_ops();
        clear_program();
        init_regs[1]  = 32'h0000_00F3;
        init_regs[5]  = 32'h8000_0000;
        init_regs[6]  = 32'd1;
        init_regs[14] = 32'hAA;
        init_regs[30] = 32'h77;
        rom[0] = enc_r(5'd10, 5'd1, 5'd6, 5'd0, 5'b00010);
        rom[1] = enc_r(5'd11, 5'd5, 5'd6, 5'd0, 5'b00011);
        rom[2] = enc_r(5'd12, 5'd6, 5'd0, 5'd4, 5'b00100);
        rom[3] = enc_r(5'd13, 5'd5, 5'd0, 5'd4, 5'b00101);
        rom[4] = enc_r(5'd14, 5'd1, 5'd6, 5'd0, 5'b00110);
        rom[5] = enc_r(5'd15, 5'd1, 5'd6, 5'd0, 5'b00000);
        rom[6] = enc_r(5'd16, 5'd6, 5'd1, 5'd0, 5'b00001);
        rom[7] = enc_i(OP_ADDI, 5'd17, 5'd1, 17'h1FFFC);
        rom[8] = enc_j(OP_J, 27'd8);
        start_program();
        run_cycles(36);
        compared++;
        if (regs[10] !== 32'd1 || regs[11] !== 32'h8000_0001) begin
            mismatched++;
            $display("FAIL alu_and_or: got %0h %0h expected 1/80000001", regs[10], regs[11]);
        end
        compared++;
        if (regs[12] !== 32'd16 || regs[13] !== 32'hF800_0000) begin
            mismatched++;
            $display("FAIL alu_shift: got %0h %0h expected 10/f8000000", regs[12], regs[13]);
        end
        compared++;
        if (regs[14] !== 32'hAA) begin
            mismatched++;
            $display("FAIL alu_nop_aluop: got %0h expected aa", regs[14]);
        end
        compared++;
        if (regs[15] !== 32'hF4 || regs[16] !== 32'hFFFF_FF0E || regs[17] !== 32'hEF) begin
            mismatched++;
            $display("FAIL alu_arith: got %0h %0h %0h expected f4/ffffff0e/ef", regs[15], regs[16], regs[17]);
        end
        compared++;
        if (regs[30] !== 32'h77) begin
            mismatched++;
            $display("FAIL alu_no_ovf: got r30=%0h expected 77", regs[30]);
        end
    endtask

    task automatic test_branches();
        clear_program();
        rom[0]  = enc_i(OP_ADDI, 5'd1, 5'd0, 17'd3);
        rom[1]  = enc_i(OP_ADDI, 5'd2, 5'd0, 17'd0);
        rom[2]  = enc_i(OP_ADDI, 5'd2, 5'd2, 17'd1);
        rom[3]  = enc_i(OP_BLT,  5'd2, 5'd1, 17'h1FFFE);
        rom[4]  = enc_j(OP_JAL, 27'd7);
        rom[5]  = enc_j(OP_J,   27'd10);
        rom[6]  = enc_i(OP_ADDI, 5'd20, 5'd0, 17'd99);
        rom[7]  = enc_i(OP_BNE,  5'd2, 5'd1, 17'd1);
        rom[8]  = enc_i(OP_ADDI, 5'd3, 5'd0, 17'd1);
        rom[9]  = enc_i(OP_JR,   5'd31, 5'd0, 17'd0);
        rom[10] = enc_i(OP_BNE,  5'd2, 5'd0, 17'd1);
        rom[11] = enc_i(OP_ADDI, 5'd21, 5'd0, 17'd99);
        rom[12] = enc_i(OP_ADDI, 5'd4, 5'd0, 17'd7);
        rom[13] = enc_j(OP_J,   27'd13);
        start_program();
        run_cycles(70);
        compared++;
        if (regs[2] !== 32'd3) begin
            mismatched++;
            $display("FAIL br_loop_count: got %0h expected 3", regs[2]);
        end
        compared++;
        if (regs[31] !== 32'd5) begin
            mismatched++;
            $display("FAIL br_jal_link: got %0h expected 5", regs[31]);
        end
        compared++;
        if (regs[3] !== 32'd1 || regs[4] !== 32'd7) begin
            mismatched++;
            $display("FAIL br_fallthrough: got r3=%0h r4=%0h expected 1/7", regs[3], regs[4]);
        end
        compared++;
        if (regs[20] !== 32'd0 || regs[21] !== 32'd0) begin
            mismatched++;
            $display("FAIL br_skipped: got r20=%0h r21=%0h expected 0/0", regs[20], regs[21]);
        end
        compared++;
        if (address_imem !== 32'd13) begin
            mismatched++;
            $display("FAIL br_final_pc: got %0h expected d", address_imem);
        end
    endtask

    task automatic test_setx_bex();
        clear_program();
        rom[0] = enc_j(OP_SETX, 27'd5);
        rom[1] = enc_j(OP_BEX,  27'd4);
        rom[2] = enc_i(OP_ADDI, 5'd5, 5'd0, 17'd1);
        rom[3] = enc_j(OP_J,    27'd3);
        rom[4] = enc_j(OP_SETX, 27'd0);
        rom[5] = enc_j(OP_BEX,  27'd8);
        rom[6] = enc_i(OP_ADDI, 5'd6, 5'd0, 17'd1);
        rom[7] = enc_j(OP_J,    27'd7);
        rom[8] = enc_i(OP_ADDI, 5'd7, 5'd0, 17'd1);
        start_program();
        run_cycles(4);
        compared++;
        if (regs[30] !== 32'd5) begin
            mismatched++;
            $display("FAIL setx_value: got %0h expected 5", regs[30]);
        end
        run_cycles(28);
        compared++;
        if (regs[5] !== 32'd0 || regs[6] !== 32'd1 || regs[7] !== 32'd0) begin
            mismatched++;
            $display("FAIL bex_paths: got r5=%0h r6=%0h r7=%0h expected 0/1/0", regs[5], regs[6], regs[7]);
        end
        compared++;
        if (regs[30] !== 32'd0 || address_imem !== 32'd7) begin
            mismatched++;
            $display("FAIL bex_final: got r30=%0h pc=%0h expected 0/7", regs[30], address_imem);
        end
    endtask

    task automatic test_ja_and_reset_abort();
        clear_program();
        rom[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 17'h2A);
        rom[1] = enc_i(OP_SW,   5'd1, 5'd0, 17'd4095);
        rom[2] = enc_i(OP_ADDI, 5'd2, 5'd0, 17'h15);
        rom[3] = enc_i(OP_SW,   5'd2, 5'd0, 17'd4095);
        rom[4] = enc_j(OP_J,    27'd4);
        start_program();
        run_cycles(8);
        compared++;
        if (JA !== 6'b101010 || ram[4095] !== 32'h2A) begin
            mismatched++;
            $display("FAIL ja_store: got JA=%0h M=%0h expected 2a/2a", JA, ram[4095]);
        end
        run_cycles(6);
        compared++;
        if (regs[2] !== 32'h15) begin
            mismatched++;
            $display("FAIL ja_setup: got r2=%0h expected 15", regs[2]);
        end
        reset = 1'b1;
        @(negedge clock);
        compared++;
        if (wren !== 1'b0 || JA !== 6'h2A) begin
            mismatched++;
            $display("FAIL abort_exec: got wren=%0b JA=%0h expected 0/2a", wren, JA);
        end
        @(posedge clock);
        #1;
        compared++;
        if (address_imem !== 32'd0 || JA !== 6'd0 || ram[4095] !== 32'h2A) begin
            mismatched++;
            $display("FAIL abort_state: got pc=%0h JA=%0h M=%0h expected 0/0/2a", address_imem, JA, ram[4095]);
        end
        reset = 1'b0;
        run_cycles(4);
        compared++;
        if (address_imem !== 32'd1 || regs[1] !== 32'h2A) begin
            mismatched++;
            $display("FAIL abort_restart: got pc=%0h r1=%0h expected 1/2a", address_imem, regs[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_store();
        test_overflow();
        test_alu_ops();
        test_branches();
        test_setx_bex();
        test_ja_and_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
